// File: rtl/counter_ctrl.sv
// Run/step/clear sequencer: debounces three buttons, owns the prescaler, strobes the counter.
// Latency: clean press to state/strobe change is DEBOUNCE_LIMIT+3 edges; outputs are registered.
// Backpressure: none; events arriving in STEP/CLEAR or below a same-cycle higher priority are dropped.
module counter_ctrl #(
    parameter int unsigned PRESCALE_WIDTH = 16,
    parameter int unsigned DEBOUNCE_LIMIT = 8,
    parameter int unsigned DEBOUNCE_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      btn_run,
    input  logic                      btn_step,
    input  logic                      btn_clear,
    input  logic                      use_prescaler,
    input  logic [PRESCALE_WIDTH-1:0] prescale_limit,
    output logic                      count_en,
    output logic                      count_clr,
    output logic                      running,
    output logic [1:0]                state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STEP  = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    localparam int unsigned NUM_BTN = 3;
    localparam logic [DEBOUNCE_WIDTH-1:0] DB_LAST = DEBOUNCE_WIDTH'(DEBOUNCE_LIMIT - 1);

    // Bit order: 0 = clear, 1 = run, 2 = step
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] level_q;
    logic [NUM_BTN-1:0] press;

    assign btn_raw = {btn_step, btn_run, btn_clear};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            level_q <= '0;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            level_q <= level;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        logic [DEBOUNCE_WIDTH-1:0] db_cnt;
        logic                      lvl;

        // Level flips on the edge where the disagreement count would reach the limit
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt <= '0;
                lvl    <= 1'b0;
            end else if (sync2[i] == lvl) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt <= '0;
                lvl    <= sync2[i];
            end else begin
                db_cnt <= db_cnt + DEBOUNCE_WIDTH'(1);
            end
        end

        assign level[i] = lvl;
    end

    assign press = level & ~level_q;

    logic evt_clear;
    logic evt_run;
    logic evt_step;

    assign evt_clear = press[0];
    assign evt_run   = press[1];
    assign evt_step  = press[2];

    logic [1:0] state_n;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (evt_clear)     state_n = ST_CLEAR;
                else if (evt_run)  state_n = ST_RUN;
                else if (evt_step) state_n = ST_STEP;
            end
            ST_RUN: begin
                if (evt_clear)     state_n = ST_CLEAR;
                else if (evt_run)  state_n = ST_IDLE;
            end
            ST_STEP:  state_n = ST_IDLE;
            ST_CLEAR: state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    logic [PRESCALE_WIDTH-1:0] pre;
    logic                      tick;
    logic                      stay_run;

    // >= rather than == so a lowered limit mid-run wraps immediately
    assign tick     = (pre >= prescale_limit);
    assign stay_run = (state == ST_RUN) && (state_n == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre       <= '0;
            count_en  <= 1'b0;
            count_clr <= 1'b0;
            running   <= 1'b0;
            state     <= ST_IDLE;
        end else begin
            if (stay_run && !tick) pre <= pre + PRESCALE_WIDTH'(1);
            else                   pre <= '0;
            count_en  <= (state_n == ST_STEP) || (stay_run && (tick || !use_prescaler));
            count_clr <= (state_n == ST_CLEAR);
            running   <= (state_n == ST_RUN);
            state     <= state_n;
        end
    end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Run/step/clear sequencer for the board demo's free-running counter datapath. It debounces three raw push-button inputs from the IO pins and owns the prescaler. It issues single-cycle count-enable and clear pulses to the counter register, so the counter itself reduces to `if (count_clr) ctr<=0; else if (count_en) ctr<=ctr+1`. It sits between the io_in pin mapping and the counter.

## Interface
- `PRESCALE_WIDTH`, 16: width of prescaler counter and `prescale_limit`.
- `DEBOUNCE_LIMIT`, 8: consecutive cycles a synchronized button must disagree with its debounced level before the level flips; ≥1.
- `DEBOUNCE_WIDTH`, 4: width of each debounce counter; must hold `DEBOUNCE_LIMIT`.

Ports:
- `clk`  in  1  sole clock; all flops rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_run`  in  1  raw, asynchronous, active-high; each press toggles run/stop.
- `btn_step`  in  1  raw, active-high; each press requests one count from IDLE.
- `btn_clear`  in  1  raw, active-high; each press requests a counter clear.
- `use_prescaler`  in  1  synchronous level; 1 = count every `prescale_limit+1` cycles in RUN, 0 = every cycle.
- `prescale_limit`  in  `PRESCALE_WIDTH`  synchronous, sampled every cycle.
- `count_en`  out  1  registered; one-cycle increment strobe.
- `count_clr`  out  1  registered; one-cycle clear strobe.
- `running`  out  1  registered; 1 while state is RUN.
- `state`  out  2  registered FSM state: IDLE=0, RUN=1, STEP=2, CLEAR=3.

## Operation
- **Reset values:** every flop clears to 0: sync stages, debounce counters, debounced levels, prescaler, state=IDLE, `count_en`=`count_clr`=`running`=0.
- **Input synchronization:** each button passes through a 2-flop synchronizer.
- **Debounce:**
  - Per button, the counter increments while the synced value ≠ the debounced level.
  - The counter clears to 0 whenever they are equal.
  - On the edge where the counter would reach `DEBOUNCE_LIMIT`, the level flips and the counter clears.
- **Press event:** one-cycle pulse = debounced level rising (registered previous level). Releases generate no event.
- **Event priority** (same cycle): clear > run > step. Lower-priority events in that cycle are dropped.
- **FSM transitions:**
  - IDLE: clear → CLEAR; run → RUN; step → STEP; else stay.
  - RUN: clear → CLEAR; run → IDLE; step ignored.
  - STEP: unconditionally → IDLE after one cycle. Any event arriving during STEP is dropped.
  - CLEAR: unconditionally → IDLE after one cycle. Any event arriving during CLEAR is dropped.
- **Prescaler:**
  - Outside RUN it is held at 0.
  - In RUN, tick = (`pre` ≥ `prescale_limit`). On tick `pre`←0, else `pre`←`pre`+1.
  - The ≥ compare makes a mid-run decrease of `prescale_limit` wrap on the next cycle.
  - `prescale_limit`=0 ticks every cycle.
- **Outputs** (all registered, computed from current state and events):
  - `count_en` next = (next state = STEP) OR (state = RUN AND staying in RUN AND (tick OR `use_prescaler`=0)). No strobe is issued on the edge that leaves RUN.
  - `count_clr` next = (next state = CLEAR).
  - `running` next = (next state = RUN).
  - `state` is the state register itself.

## Timing
- Raw button change → synced value: 2 edges.
- Synced value held → debounced level flips after `DEBOUNCE_LIMIT` further edges.
- Debounced rise → state, `count_en`/`count_clr`/`running` change on the next edge.
- Total press latency with clean input: `DEBOUNCE_LIMIT`+3 edges.
- Bounce shorter than `DEBOUNCE_LIMIT` cycles produces no event.
- **RUN with `use_prescaler`=1, limit L** (cycle 0 = first cycle with `running`=1): `count_en` is high in cycles L+1, 2L+2, …, i.e. period L+1.
- **RUN with `use_prescaler`=0:** `count_en` is high every cycle from cycle 1.
- **STEP:** `count_en` is high for exactly one cycle, the STEP cycle.
- **CLEAR:** `count_clr` is high for exactly one cycle, the CLEAR cycle. `count_en` is 0 in that cycle.
- **Reset mid-operation:** outputs drop asynchronously. A button held through reset release registers as a press after `DEBOUNCE_LIMIT`+3 edges.

## Test plan
- Reset, then 20 cycles idle → all outputs 0, state=0.
- Run press (limit=4, prescaler on), clean, `DEBOUNCE_LIMIT`=8 → `running` rises 11 edges after the raw change; `count_en` pulses every 5 cycles; second press → IDLE with no trailing pulse.
- Run press with 3-cycle glitches repeated 5 times, then stable → no event from the glitches; exactly one RUN entry after stable input.
- Step press in IDLE → one `count_en` cycle with state=2, then state=0. Step press while RUN → no state change, cadence unchanged.
- Clear and run debounced in the same cycle while RUN → state=3 for one cycle with `count_clr`=1, then IDLE.
- In RUN with limit 100 and `pre`≈50, change limit to 10 → tick on the next cycle, then period 11. `use_prescaler`=0 → `count_en` continuous.
